load_store_unit: RTL

Initiator for the word-addressed data memory: accepts byte/half/word load and store requests from the CPU pipeline over a valid/ready handshake. It drives the memory's Address/MemRead/MemWrite/WriteData and samples ReadData. Sub-word stores are done as read-modify-write. Load data is returned aligned and sign- or zero-extended, with a one-cycle response pulse. It sits between the execute stage and the data memory.

---
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Bundle between the execute stage, the load/store unit and the word-addressed data memory.
// The slave modport is the unit's view; the master modport is the CPU-plus-memory side.
interface load_store_unit_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic        RespError;
    logic [31:0] RespRData;
    logic [31:0] Address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, ReadData,
        output ReqReady, RespValid, RespError, RespRData, Address, MemRead, MemWrite, WriteData
    );

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, ReadData,
        input  ReqReady, RespValid, RespError, RespRData, Address, MemRead, MemWrite, WriteData
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-addressed memory, sub-word stores done
// as read-modify-write, loads returned lane-aligned and sign- or zero-extended.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_off;
    logic [15:0] r_sub_wdata;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic        r_err;

    logic        w_accept;
    logic        w_err;
    logic        w_word_store;

    function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic sgn);
        logic [31:0] w_sh;
        w_sh = word >> {off, 3'b000};
        case (size)
            2'b00:   f_extend = {{24{sgn & w_sh[7]}}, w_sh[7:0]};
            2'b01:   f_extend = {{16{sgn & w_sh[15]}}, w_sh[15:0]};
            default: f_extend = word;
        endcase
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [1:0] off,
                                            input logic [1:0] size, input logic [15:0] data);
        logic [31:0] w_mask;
        logic [31:0] w_lanes;
        if (size == 2'b00) begin
            w_mask  = 32'h0000_00ff << {off, 3'b000};
            w_lanes = {4{data[7:0]}};
        end else begin
            w_mask  = 32'h0000_ffff << {off, 3'b000};
            w_lanes = {2{data}};
        end
        f_merge = (word & ~w_mask) | (w_lanes & w_mask);
    endfunction

    assign w_accept     = bus.ReqValid && (r_state == IDLE);
    assign w_word_store = bus.ReqWrite && (bus.ReqSize == 2'b10);
    assign w_err        = (bus.ReqSize == 2'b11)
                       || ((bus.ReqSize == 2'b01) && bus.ReqAddr[0])
                       || ((bus.ReqSize == 2'b10) && (bus.ReqAddr[1:0] != 2'b00))
                       || ({2'b00, bus.ReqAddr[31:2]} >= MEM_WORDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err)             w_state_nxt = RESP;
                    else if (w_word_store) w_state_nxt = WRITE;
                    else                   w_state_nxt = READ;
                end
            end
            READ:    w_state_nxt = r_write ? WRITE : RESP;
            WRITE:   w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_off       <= 2'b00;
            r_sub_wdata <= 16'h0;
            r_addr      <= 30'h0;
            r_wdata     <= 32'h0;
            r_buf       <= 32'h0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_write     <= bus.ReqWrite;
            r_size      <= bus.ReqSize;
            r_signed    <= bus.ReqSigned;
            r_off       <= bus.ReqAddr[1:0];
            r_sub_wdata <= bus.ReqWData[15:0];
            r_addr      <= bus.ReqAddr[31:2];
            r_err       <= w_err;
            if (!w_err && w_word_store) begin
                r_wdata <= bus.ReqWData;
            end
        end else if (r_state == READ) begin
            r_buf <= bus.ReadData;
            // Merged word is registered here so it is stable for the whole WRITE cycle.
            if (r_write) begin
                r_wdata <= f_merge(bus.ReadData, r_off, r_size, r_sub_wdata);
            end
        end
    end

    assign bus.ReqReady  = (r_state == IDLE) && rst_n;
    assign bus.MemRead   = (r_state == READ);
    assign bus.MemWrite  = (r_state == WRITE);
    assign bus.RespValid = (r_state == RESP);
    assign bus.RespError = (r_state == RESP) && r_err;
    assign bus.Address   = {2'b00, r_addr};
    assign bus.WriteData = r_wdata;
    assign bus.RespRData = ((r_state == RESP) && !r_write && !r_err)
                         ? f_extend(r_buf, r_off, r_size, r_signed) : 32'h0;

endmodule
